id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage of the MIPS core, directly downstream of the opcode decoder. Registers the
//  decoder's 8-bit control word, operands, immediate and register indices into EX.
//  Contains load-use hazard detection: emits stall_o and inserts a bubble.
//  Also handles branch/jump flush and global hold, and counts load-use bubbles.
// PARAMETERS
//  DATA_W  32  operand / immediate width
//  REG_W    5  register index width
//  CTRL_W   8  control word width {RegDst,ALUSrc,ALUOp[1:0],MemWrite,MemRead,MemtoReg,RegWrite}
//  CNT_W   16  stall counter width
// PORTS
//  clk_i         in   1       clock
//  rst_n_i       in   1       reset; one clock; reset is asynchronous and active-low
//  ctrl_i        in   CTRL_W  decoder control word (low byte of decoder output)
//  rs_data_i     in   DATA_W  register file read data, rs
//  rt_data_i     in   DATA_W  register file read data, rt
//  imm_i         in   DATA_W  sign-extended immediate
//  funct_i       in   6       instr[5:0]
//  rs_i/rt_i/rd_i in  REG_W   instr[25:21] / [20:16] / [15:11]
//  flush_i       in   1       branch taken or jump; kill the ID instruction
//  hold_i        in   1       global freeze (memory wait)
//  ex_ctrl_o     out  CTRL_W  registered control word
//  ex_rs_data_o / ex_rt_data_o / ex_imm_o  out DATA_W  registered operands
//  ex_funct_o    out  6       registered funct
//  ex_rs_o / ex_rt_o  out REG_W  registered indices (for forwarding)
//  ex_wreg_o     out  REG_W   destination = RegDst ? rd_i : rt_i, resolved in ID and registered
//  ex_valid_o    out  1       EX holds a real instruction
//  stall_o       out  1       combinational load-use stall; freezes PC and IF/ID
//  stall_cnt_o   out  CNT_W   count of load-use bubbles inserted
// BEHAVIOUR
//  - Reset (rst_n_i=0, no clock edge needed): all registered outputs = 0, incl. ex_valid_o and
//    stall_cnt_o. Reset deassertion takes effect at the next rising edge.
//  - Latency: 1 cycle. ID values at edge N appear on ex_* after edge N.
//  - stall_o = ex_valid_o & ex_ctrl_o[2] (MemRead) & (ex_rt_o != 0)
//              & (ex_rt_o == rs_i | ex_rt_o == rt_i).
//    stall_o is pure combinational and is independent of hold_i and flush_i.
//  - Per-edge priority, highest first:
//    1. hold_i=1: every register keeps its value, counter included.
//    2. flush_i=1: bubble. Counter is not incremented.
//    3. stall_o=1: bubble; stall_cnt_o += 1, saturating at all-ones.
//    4. Otherwise: load all ex_* from the ID inputs; ex_valid_o <= 1.
//  - Bubble: every ex_* output is set to 0, including data fields, and ex_valid_o <= 0.
//  - A load-use stall lasts exactly 1 cycle, because the bubble clears ex_valid_o.
//    After the bubble, the held ID instruction loads on the next edge.
//  - If flush_i and stall_o are both 1: flush wins; the stall is not counted.
//  - If hold_i and flush_i are both 1: hold wins. Upstream keeps flush_i asserted until hold_i drops.
//  - No arithmetic on data; fields pass through bit-exact. The counter wraps never; it saturates.
// TESTING
//  1. addi $8,$0,5: ctrl_i=8'h41, rt_i=8, rd_i=0, imm_i=5
//     -> after 1 edge: ex_ctrl_o=41, ex_wreg_o=8, ex_imm_o=5, ex_valid_o=1, stall_o=0.
//  2. EX holds lw $9 (ex_ctrl_o=8'h57, ex_rt_o=9); ID has add with rs_i=9
//     -> stall_o=1 in the same cycle.
//     -> next edge: ex_ctrl_o=0, ex_valid_o=0, stall_cnt_o=1.
//     -> following edge: the add loads and stall_o=0.
//  3. EX holds lw $0 (ex_rt_o=0, 8'h57); ID has rs_i=0
//     -> stall_o=0; the instruction loads normally and the counter is unchanged.
//  4. stall_o=1 and flush_i=1 together -> bubble; stall_cnt_o unchanged.
//     Then hold_i=1 with flush_i=1 -> all outputs frozen for the held cycles.
//  5. Drive rst_n_i=0 mid-stream, between clock edges
//     -> all outputs 0 immediately; held 0 through edges while low.
//  6. CNT_W=2: force 5 consecutive load-use bubbles -> stall_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch/jump flush, global hold and a saturating load-use bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [5:0]        funct_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [5:0]        ex_funct_o,
  output logic [REG_W-1:0]  ex_rs_o,
  output logic [REG_W-1:0]  ex_rt_o,
  output logic [REG_W-1:0]  ex_wreg_o,
  output logic              ex_valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned REGDST_BIT  = 7;
  localparam int unsigned MEMREAD_BIT = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [DATA_W-1:0] rs_dat_q, rs_dat_d;
  logic [DATA_W-1:0] rt_dat_q, rt_dat_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [5:0]        funct_q,  funct_d;
  logic [REG_W-1:0]  rs_q,     rs_d;
  logic [REG_W-1:0]  rt_q,     rt_d;
  logic [REG_W-1:0]  wreg_q,   wreg_d;
  logic              valid_q,  valid_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              stall;

  always_comb begin
    stall = valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != '0) &
            ((rt_q == rs_i) | (rt_q == rt_i));
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    rs_dat_d = rs_dat_q;
    rt_dat_d = rt_dat_q;
    imm_d    = imm_q;
    funct_d  = funct_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wreg_d   = wreg_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (hold_i) begin
      // freeze everything, counter included
    end else if (flush_i || stall) begin
      ctrl_d   = '0;
      rs_dat_d = '0;
      rt_dat_d = '0;
      imm_d    = '0;
      funct_d  = '0;
      rs_d     = '0;
      rt_d     = '0;
      wreg_d   = '0;
      valid_d  = 1'b0;
      // only a genuine load-use bubble counts; flush takes priority
      if (!flush_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
    end else begin
      ctrl_d   = ctrl_i;
      rs_dat_d = rs_data_i;
      rt_dat_d = rt_data_i;
      imm_d    = imm_i;
      funct_d  = funct_i;
      rs_d     = rs_i;
      rt_d     = rt_i;
      wreg_d   = ctrl_i[REGDST_BIT] ? rd_i : rt_i;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q   <= '0;
      rs_dat_q <= '0;
      rt_dat_q <= '0;
      imm_q    <= '0;
      funct_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rs_dat_q <= rs_dat_d;
      rt_dat_q <= rt_dat_d;
      imm_q    <= imm_d;
      funct_q  <= funct_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wreg_q   <= wreg_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_ctrl_o    = ctrl_q;
  assign ex_rs_data_o = rs_dat_q;
  assign ex_rt_data_o = rt_dat_q;
  assign ex_imm_o     = imm_q;
  assign ex_funct_o   = funct_q;
  assign ex_rs_o      = rs_q;
  assign ex_rt_o      = rt_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_valid_o   = valid_q;
  assign stall_o      = stall;
  assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against an instruction-level model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ctrl_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [5:0]  funct_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic        flush_i, hold_i;

  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rsd, ex_rtd, ex_imm;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_valid, stall;
  logic [15:0] cnt;

  logic [7:0]  b_ctrl;
  logic [31:0] b_rsd, b_rtd, b_imm;
  logic [5:0]  b_funct;
  logic [4:0]  b_rs, b_rt, b_wreg;
  logic        b_valid, b_stall;
  logic [1:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .imm_i(imm_i), .funct_i(funct_i), .rs_i(rs_i),
    .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_ctrl_o(ex_ctrl), .ex_rs_data_o(ex_rsd), .ex_rt_data_o(ex_rtd),
    .ex_imm_o(ex_imm), .ex_funct_o(ex_funct), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_wreg_o(ex_wreg), .ex_valid_o(ex_valid), .stall_o(stall), .stall_cnt_o(cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .imm_i(imm_i), .funct_i(funct_i), .rs_i(rs_i),
    .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_ctrl_o(b_ctrl), .ex_rs_data_o(b_rsd), .ex_rt_data_o(b_rtd),
    .ex_imm_o(b_imm), .ex_funct_o(b_funct), .ex_rs_o(b_rs), .ex_rt_o(b_rt),
    .ex_wreg_o(b_wreg), .ex_valid_o(b_valid), .stall_o(b_stall), .stall_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what instruction EX holds, described as plain fields.
  logic [7:0]  m_ctrl;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [5:0]  m_funct;
  logic [4:0]  m_rs, m_rt, m_wreg;
  logic        m_valid;
  int          m_cnt16, m_cnt2;

  wire [141:0] dut_vec = {ex_ctrl, ex_rsd, ex_rtd, ex_imm, ex_funct, ex_rs, ex_rt,
                          ex_wreg, ex_valid, cnt};

  function automatic logic [141:0] exp_vec();
    logic [15:0] c;
    c = 16'(m_cnt16);
    return {m_ctrl, m_rsd, m_rtd, m_imm, m_funct, m_rs, m_rt, m_wreg, m_valid, c};
  endfunction

  function automatic logic model_stall();
    // EX is a real load writing a nonzero register that the ID instruction reads
    return m_valid && m_ctrl[2] && (m_rt != 5'd0) && (m_rt == rs_i || m_rt == rt_i);
  endfunction

  task automatic model_clear(input logic clear_cnt);
    m_ctrl = '0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_funct = '0;
    m_rs = '0; m_rt = '0; m_wreg = '0; m_valid = 1'b0;
    if (clear_cnt) begin m_cnt16 = 0; m_cnt2 = 0; end
  endtask

  task automatic step();
    logic st;
    @(posedge clk);
    st = model_stall();
    if (!rst_n) model_clear(1'b1);
    else if (hold_i) begin end
    else if (flush_i) model_clear(1'b0);
    else if (st) begin
      model_clear(1'b0);
      if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
      if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
    end else begin
      m_ctrl = ctrl_i; m_rsd = rs_data_i; m_rtd = rt_data_i; m_imm = imm_i;
      m_funct = funct_i; m_rs = rs_i; m_rt = rt_i;
      m_wreg = ctrl_i[7] ? rd_i : rt_i;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic set_id(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    ctrl_i = c; rs_i = rs; rt_i = rt; rd_i = rd;
    rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    funct_i = 6'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    set_id(8'h57, 5'd3, 5'd3, 5'd4);
    model_clear(1'b1);
    #3;
    checks++;
    if (dut_vec !== '0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", dut_vec);
    end
    step(); step();
    checks++;
    if (dut_vec !== exp_vec() || b_cnt !== 2'd0) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    set_id(8'h41, 5'd0, 5'd8, 5'd0);
    imm_i = 32'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL addi_stall got=%b exp=0", stall); end
    step();
    checks++;
    if (ex_ctrl !== 8'h41 || ex_wreg !== 5'd8 || ex_imm !== 32'd5 || ex_valid !== 1'b1
        || stall !== 1'b0) begin
      failures++;
      $display("FAIL addi ctrl=%h wreg=%0d imm=%0d valid=%b stall=%b exp 41/8/5/1/0",
               ex_ctrl, ex_wreg, ex_imm, ex_valid, stall);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL addi_all got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_load_use();
    set_id(8'h57, 5'd2, 5'd9, 5'd0);
    step();
    set_id(8'h81, 5'd9, 5'd4, 5'd10);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b exp=1", stall); end
    step();
    checks++;
    if (ex_ctrl !== 8'h00 || ex_valid !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_bubble ctrl=%h valid=%b cnt=%0d exp 00/0/1", ex_ctrl, ex_valid, cnt);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL load_use_bubble_all got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    checks++;
    if (ex_ctrl !== 8'h81 || ex_wreg !== 5'd10 || ex_valid !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL load_use_after ctrl=%h wreg=%0d valid=%b stall=%b exp 81/10/1/0",
               ex_ctrl, ex_wreg, ex_valid, stall);
    end
  endtask

  task automatic test_lw_zero();
    int c0;
    set_id(8'h57, 5'd1, 5'd0, 5'd0);
    step();
    c0 = m_cnt16;
    set_id(8'h41, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lw_zero_stall got=%b exp=0", stall); end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_ctrl !== 8'h41 || cnt !== 16'(c0)) begin
      failures++;
      $display("FAIL lw_zero_load valid=%b ctrl=%h cnt=%0d exp 1/41/%0d", ex_valid, ex_ctrl, cnt, c0);
    end
  endtask

  task automatic test_flush_hold();
    int c0;
    set_id(8'h57, 5'd0, 5'd12, 5'd0);
    step();
    c0 = m_cnt16;
    set_id(8'h81, 5'd12, 5'd1, 5'd2);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL flush_stall got=%b exp=1", stall); end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || cnt !== 16'(c0)) begin
      failures++;
      $display("FAIL flush_bubble valid=%b ctrl=%h cnt=%0d exp 0/00/%0d", ex_valid, ex_ctrl, cnt, c0);
    end
    flush_i = 1'b0;
    set_id(8'hC3, 5'd5, 5'd6, 5'd7);
    step();
    hold_i = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step();
      checks++;
      if (dut_vec !== exp_vec() || ex_ctrl !== 8'hC3 || ex_wreg !== 5'd7) begin
        failures++; $display("FAIL hold_freeze got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    hold_i = 1'b0;
    step();
    checks++;
    if (dut_vec !== exp_vec() || ex_valid !== 1'b0) begin
      failures++; $display("FAIL flush_after_hold got=%h exp=%h", dut_vec, exp_vec());
    end
    flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    set_id(8'hC1, 5'd3, 5'd4, 5'd5);
    step();
    #3;
    rst_n = 1'b0;
    model_clear(1'b1);
    #1;
    checks++;
    if (dut_vec !== '0 || b_cnt !== 2'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", dut_vec);
    end
    step(); step();
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL async_reset_held got=%h exp=0", dut_vec); end
    rst_n = 1'b1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || ex_valid !== 1'b1) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    rst_n = 1'b0; #2; model_clear(1'b1); step(); rst_n = 1'b1;
    set_id(8'h57, 5'd9, 5'd9, 5'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (b_cnt !== want[i] || b_valid !== 1'b0) begin
        failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, b_cnt, want[i]);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
      if ($urandom_range(0, 1) == 1) ctrl_i[2] = 1'b1;
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i  = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        failures++; $display("FAIL rand_stall[%0d] got=%b exp=%b", i, stall, model_stall());
      end
      step();
      checks++;
      if (dut_vec !== exp_vec() || b_cnt !== 2'(m_cnt2)) begin
        failures++;
        $display("FAIL rand_state[%0d] got=%h exp=%h cnt2=%0d exp=%0d",
                 i, dut_vec, exp_vec(), b_cnt, m_cnt2);
      end
    end
    flush_i = 1'b0; hold_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_lw_zero();
    test_flush_hold();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
